// File: rtl/gpu_cmd_scheduler_if.sv
// Sprite-blit command channel: valid/ready handshake plus the command fields.
// The producer of a command uses the master modport and the consumer uses the slave modport.
interface gpu_cmd_scheduler_if;
  logic        valid;
  logic        ready;
  logic [15:0] start_x;
  logic [15:0] start_y;
  logic [15:0] width;
  logic [15:0] height;
  logic [15:0] scale_x;
  logic [15:0] scale_y;
  logic        mirror_x;
  logic        mirror_y;

  modport master (
    output valid, start_x, start_y, width, height, scale_x, scale_y, mirror_x, mirror_y,
    input  ready
  );

  modport slave (
    input  valid, start_x, start_y, width, height, scale_x, scale_y, mirror_x, mirror_y,
    output ready
  );
endinterface

// File: rtl/gpu_cmd_scheduler.sv
// Queues sprite-blit commands and issues them one at a time to the pixel pipeline, counting completions.
// The optional completion interrupt is enabled by defining GPU_SCHED_IRQ_EN.
module gpu_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int DONE_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  gpu_cmd_scheduler_if.slave            re,
  gpu_cmd_scheduler_if.master           se,
  input  logic                          px_done,
  input  logic                          abort,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          cmd_done,
  output logic [DONE_CNT_W-1:0]         done_count
`ifdef GPU_SCHED_IRQ_EN
  ,
  input  logic                          irq_en,
  input  logic                          irq_clear,
  output logic                          irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [15:0] start_x;
    logic [15:0] start_y;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] scale_x;
    logic [15:0] scale_y;
    logic        mirror_x;
    logic        mirror_y;
  } cmd_t;

  cmd_t                  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_en_q;
  state_t                state_q, state_d;
  cmd_t                  se_cmd_q, se_cmd_d;
  logic                  se_valid_q, se_valid_d;
  logic [31:0]           remaining_q, remaining_d;
  logic                  cmd_done_q, cmd_done_d;
  logic [DONE_CNT_W-1:0] done_count_q, done_count_d;
  logic                  push_s, pop_s;
  cmd_t                  head_s, in_cmd_s;

  assign in_cmd_s = '{start_x: re.start_x, start_y: re.start_y, width: re.width, height: re.height,
                      scale_x: re.scale_x, scale_y: re.scale_y, mirror_x: re.mirror_x,
                      mirror_y: re.mirror_y};
  assign head_s   = fifo_q[rd_ptr_q];

  // ready_en_q keeps re.ready low until the first clock edge after reset release
  assign re.ready = ready_en_q && (count_q < CNT_W'(FIFO_DEPTH)) && !abort;
  assign push_s   = re.valid && re.ready;

  assign se.valid    = se_valid_q;
  assign se.start_x  = se_cmd_q.start_x;
  assign se.start_y  = se_cmd_q.start_y;
  assign se.width    = se_cmd_q.width;
  assign se.height   = se_cmd_q.height;
  assign se.scale_x  = se_cmd_q.scale_x;
  assign se.scale_y  = se_cmd_q.scale_y;
  assign se.mirror_x = se_cmd_q.mirror_x;
  assign se.mirror_y = se_cmd_q.mirror_y;

  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign level      = count_q;
  assign cmd_done   = cmd_done_q;
  assign done_count = done_count_q;

  always_comb begin
    state_d      = state_q;
    pop_s        = 1'b0;
    se_valid_d   = se_valid_q;
    se_cmd_d     = se_cmd_q;
    remaining_d  = remaining_q;
    cmd_done_d   = 1'b0;
    done_count_d = done_count_q;
    if (abort) begin
      state_d     = IDLE;
      se_valid_d  = 1'b0;
      remaining_d = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop_s = 1'b1;
            // empty blits complete immediately but are not counted in done_count
            if ((head_s.width == 16'd0) || (head_s.height == 16'd0)) begin
              cmd_done_d = 1'b1;
            end else begin
              se_cmd_d    = head_s;
              se_valid_d  = 1'b1;
              remaining_d = {16'd0, head_s.width} * {16'd0, head_s.height};
              state_d     = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (se_valid_q && se.ready) begin
            se_valid_d = 1'b0;
            state_d    = DRAIN;
          end
        end
        DRAIN: begin
          if (px_done) begin
            if (remaining_q == 32'd1) begin
              remaining_d  = 32'd0;
              cmd_done_d   = 1'b1;
              done_count_d = done_count_q + DONE_CNT_W'(1);
              state_d      = IDLE;
            end else begin
              remaining_d = remaining_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) fifo_q[wr_ptr_q] <= in_cmd_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_en_q   <= 1'b0;
      se_cmd_q     <= '0;
      se_valid_q   <= 1'b0;
      remaining_q  <= 32'd0;
      cmd_done_q   <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_en_q   <= 1'b1;
      se_cmd_q     <= se_cmd_d;
      se_valid_q   <= se_valid_d;
      remaining_q  <= remaining_d;
      cmd_done_q   <= cmd_done_d;
      done_count_q <= done_count_d;
    end
  end

`ifdef GPU_SCHED_IRQ_EN
  logic irq_q, irq_d;

  // sticky interrupt once the queue is fully drained; a new set wins over clear
  always_comb begin
    irq_d = irq_q;
    if (irq_clear) irq_d = 1'b0;
    if (cmd_done_d && irq_en && (count_d == '0)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Directed self-checking bench for gpu_cmd_scheduler; the interrupt scenario is built when
// GPU_SCHED_IRQ_EN is defined.
module tb_gpu_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        px_done;
  logic        abort;
  logic        busy;
  logic [2:0]  level;
  logic        cmd_done;
  logic [15:0] done_count;
`ifdef GPU_SCHED_IRQ_EN
  logic irq_en, irq_clear, irq;
`endif
  int errors = 0;
  int checks = 0;

  gpu_cmd_scheduler_if re_if ();
  gpu_cmd_scheduler_if se_if ();

  gpu_cmd_scheduler dut (
    .clk(clk), .rst(rst), .re(re_if), .se(se_if), .px_done(px_done), .abort(abort),
    .busy(busy), .level(level), .cmd_done(cmd_done), .done_count(done_count)
`ifdef GPU_SCHED_IRQ_EN
    , .irq_en(irq_en), .irq_clear(irq_clear), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [15:0] w, input logic [15:0] h);
    re_if.valid    = 1'b1;
    re_if.width    = w;
    re_if.height   = h;
    re_if.start_x  = 16'd10;
    re_if.start_y  = 16'd20;
    re_if.scale_x  = 16'hFF80;
    re_if.scale_y  = 16'h0100;
    re_if.mirror_x = 1'b1;
    re_if.mirror_y = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; px_done = 1'b0; abort = 1'b0; se_if.ready = 1'b0;
    re_if.valid = 1'b0; re_if.width = 16'd0; re_if.height = 16'd0; re_if.start_x = 16'd0;
    re_if.start_y = 16'd0; re_if.scale_x = 16'd0; re_if.scale_y = 16'd0;
    re_if.mirror_x = 1'b0; re_if.mirror_y = 1'b0;
`ifdef GPU_SCHED_IRQ_EN
    irq_en = 1'b0; irq_clear = 1'b0;
`endif
    step(); step();
    checks++; if (re_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", re_if.ready); end
    checks++; if (se_if.valid !== 1'b0 || se_if.width !== 16'd0 || se_if.start_x !== 16'd0) begin errors++; $display("FAIL reset_se: valid %b width %h sx %h want 0", se_if.valid, se_if.width, se_if.start_x); end
    checks++; if (level !== 3'd0 || busy !== 1'b0 || cmd_done !== 1'b0 || done_count !== 16'd0) begin errors++; $display("FAIL reset_status: level %0d busy %b done %b cnt %0d want 0", level, busy, cmd_done, done_count); end
`ifdef GPU_SCHED_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (re_if.ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", re_if.ready); end
    step();
    checks++; if (re_if.ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", re_if.ready); end
  endtask

  task automatic test_single_cmd();
    se_if.ready = 1'b1;
    drive_cmd(16'd4, 16'd2);
    step();
    re_if.valid = 1'b0;
    checks++; if (level !== 3'd1 || se_if.valid !== 1'b0) begin errors++; $display("FAIL accept: level %0d se_valid %b want 1/0", level, se_if.valid); end
    step();
    checks++; if (se_if.valid !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL issue_latency: se_valid %b level %0d want 1/0", se_if.valid, level); end
    checks++; if (se_if.width !== 16'd4 || se_if.height !== 16'd2 || se_if.start_x !== 16'd10 || se_if.start_y !== 16'd20 || se_if.scale_x !== 16'hFF80 || se_if.scale_y !== 16'h0100 || se_if.mirror_x !== 1'b1 || se_if.mirror_y !== 1'b0) begin
      errors++; $display("FAIL issue_fields: w %h h %h sx %h sy %h scx %h scy %h mx %b my %b want 4 2 a 14 ff80 100 1 0", se_if.width, se_if.height, se_if.start_x, se_if.start_y, se_if.scale_x, se_if.scale_y, se_if.mirror_x, se_if.mirror_y);
    end
    step();
    checks++; if (se_if.valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL handshake: se_valid %b busy %b want 0/1", se_if.valid, busy); end
    for (int i = 0; i < 8; i++) begin
      px_done = 1'b1;
      step();
      checks++; if (cmd_done !== (i == 7)) begin errors++; $display("FAIL drain_px%0d: cmd_done %b want %b", i, cmd_done, (i == 7)); end
    end
    px_done = 1'b0;
    checks++; if (done_count !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL complete: count %0d busy %b want 1/0", done_count, busy); end
    step();
    checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", cmd_done); end
  endtask

  task automatic test_backpressure_fill();
    se_if.ready = 1'b0;
    drive_cmd(16'd2, 16'd1);
    step();
    re_if.valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_cmd(16'(3 + i), 16'd1);
      else re_if.valid = 1'b0;
      step();
      checks++; if (se_if.valid !== 1'b1 || se_if.width !== 16'd2 || level !== 3'((i < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL stall%0d: se_valid %b width %0d level %0d want 1 2 %0d", i, se_if.valid, se_if.width, level, (i < 4) ? i + 1 : 4);
      end
    end
    checks++; if (re_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", re_if.ready); end
    se_if.ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin px_done = 1'b1; step(); end
    px_done = 1'b0;
    checks++; if (cmd_done !== 1'b1 || done_count !== 16'd2 || level !== 3'd4) begin errors++; $display("FAIL drain_a: done %b cnt %0d level %0d want 1 2 4", cmd_done, done_count, level); end
    step();
    checks++; if (se_if.valid !== 1'b1 || se_if.width !== 16'd3 || level !== 3'd3) begin errors++; $display("FAIL issue_b: valid %b width %0d level %0d want 1 3 3", se_if.valid, se_if.width, level); end
    step();
    for (int i = 0; i < 3; i++) begin px_done = 1'b1; step(); end
    px_done = 1'b0;
    checks++; if (cmd_done !== 1'b1 || done_count !== 16'd3) begin errors++; $display("FAIL drain_b: done %b cnt %0d want 1 3", cmd_done, done_count); end
    drive_cmd(16'd9, 16'd1);
    step();
    re_if.valid = 1'b0;
    checks++; if (level !== 3'd3 || se_if.valid !== 1'b1 || se_if.width !== 16'd4) begin errors++; $display("FAIL push_pop_same: level %0d valid %b width %0d want 3 1 4", level, se_if.valid, se_if.width); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (level !== 3'd0 || se_if.valid !== 1'b0) begin errors++; $display("FAIL cleanup_abort: level %0d valid %b want 0/0", level, se_if.valid); end
  endtask

  task automatic test_zero_size();
    drive_cmd(16'd0, 16'd7);
    step();
    drive_cmd(16'd1, 16'd1);
    step();
    re_if.valid = 1'b0;
    checks++; if (cmd_done !== 1'b1 || se_if.valid !== 1'b0 || level !== 3'd1 || done_count !== 16'd3) begin
      errors++; $display("FAIL drop_empty: done %b valid %b level %0d cnt %0d want 1 0 1 3", cmd_done, se_if.valid, level, done_count);
    end
    step();
    checks++; if (se_if.valid !== 1'b1 || se_if.width !== 16'd1 || cmd_done !== 1'b0) begin errors++; $display("FAIL issue_after_drop: valid %b width %0d done %b want 1 1 0", se_if.valid, se_if.width, cmd_done); end
    step();
    px_done = 1'b1;
    step();
    px_done = 1'b0;
    checks++; if (cmd_done !== 1'b1 || done_count !== 16'd4) begin errors++; $display("FAIL one_pixel: done %b cnt %0d want 1 4", cmd_done, done_count); end
  endtask

  task automatic test_max_size();
    drive_cmd(16'hFFFF, 16'hFFFF);
    step();
    re_if.valid = 1'b0;
    step();
    checks++; if (dut.remaining_q !== 32'hFFFE0001) begin errors++; $display("FAIL max_remaining: got %h want fffe0001", dut.remaining_q); end
    step();
    for (int i = 0; i < 3; i++) begin px_done = 1'b1; step(); end
    px_done = 1'b0;
    checks++; if (dut.remaining_q !== 32'hFFFDFFFE || cmd_done !== 1'b0) begin errors++; $display("FAIL max_decrement: got %h done %b want fffdfffe 0", dut.remaining_q, cmd_done); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (dut.remaining_q !== 32'd0 || done_count !== 16'd4) begin errors++; $display("FAIL max_abort: rem %h cnt %0d want 0 4", dut.remaining_q, done_count); end
  endtask

  task automatic test_abort();
    drive_cmd(16'd2, 16'd2);
    step();
    re_if.valid = 1'b0;
    step();
    step();
    drive_cmd(16'd3, 16'd3);
    step();
    step();
    checks++; if (level !== 3'd2 || se_if.valid !== 1'b0) begin errors++; $display("FAIL queued_in_drain: level %0d valid %b want 2 0", level, se_if.valid); end
    abort = 1'b1;
    #1;
    checks++; if (re_if.ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", re_if.ready); end
    step();
    abort = 1'b0;
    re_if.valid = 1'b0;
    checks++; if (level !== 3'd0 || se_if.valid !== 1'b0 || cmd_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_flush: level %0d valid %b done %b busy %b want 0 0 0 0", level, se_if.valid, cmd_done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      px_done = 1'b1;
      step();
      checks++; if (cmd_done !== 1'b0 || done_count !== 16'd4) begin errors++; $display("FAIL stray_px%0d: done %b cnt %0d want 0 4", i, cmd_done, done_count); end
    end
    px_done = 1'b0;
  endtask

`ifdef GPU_SCHED_IRQ_EN
  task automatic test_irq();
    irq_en = 1'b1;
    se_if.ready = 1'b1;
    drive_cmd(16'd1, 16'd1);
    step();
    step();
    re_if.valid = 1'b0;
    step();
    px_done = 1'b1;
    step();
    px_done = 1'b0;
    checks++; if (cmd_done !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL irq_first: done %b irq %b want 1 0", cmd_done, irq); end
    step();
    step();
    px_done = 1'b1;
    irq_clear = 1'b1;
    step();
    px_done = 1'b0;
    checks++; if (cmd_done !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: done %b irq %b want 1 1", cmd_done, irq); end
    step();
    irq_clear = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_cmd();
    test_backpressure_fill();
    test_zero_size();
    test_max_size();
    test_abort();
`ifdef GPU_SCHED_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
